sign_mag_mult16: RTL and testbench
==================================

SIGN_MAG_MULT16 -- requirements
Module: sign_mag_mult16

Interface
REQ-001 Parameter WIDTH, default 16, operand magnitude width; product width is 2*WIDTH.
REQ-002 clk  input  1  rising-edge clock; the block's single clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair present.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 mag_a  input  WIDTH  unsigned magnitude of operand A, from the upstream absolute-value stage.
REQ-007 mag_b  input  WIDTH  unsigned magnitude of operand B, from the upstream absolute-value stage.
REQ-008 sign_a  input  1  original sign of A; 1 = negative.
REQ-009 sign_b  input  1  original sign of B; 1 = negative.
REQ-010 out_valid  output  1  product present.
REQ-011 out_ready  input  1  consumer takes the product.
REQ-012 product  output  2*WIDTH  two's-complement signed product.
REQ-013 busy  output  1  high in BUSY state only.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE with in_valid=1 at a rising edge (the accept edge) SHALL do all of the following:
  - latch mag_a into the multiplicand register, zero-extended to 2*WIDTH;
  - latch mag_b into the multiplier register;
  - latch sign_a XOR sign_b as the result sign;
  - clear the accumulator and the iteration counter;
  - go to BUSY.
REQ-017 Each BUSY edge SHALL do all of the following:
  - add the multiplicand to the accumulator if multiplier bit 0 is 1;
  - shift the multiplicand left by 1;
  - shift the multiplier right by 1;
  - increment the counter.
REQ-018 The BUSY edge on which the counter reaches WIDTH SHALL move the FSM to DONE; latency from accept edge to out_valid=1 is exactly WIDTH edges (16 at default).
REQ-019 On entry to DONE, product SHALL equal the accumulator if the result sign is 0 or the accumulator is 0, and the two's-complement negation of the accumulator otherwise.
REQ-020 Negative zero SHALL never be produced.
REQ-021 product and out_valid SHALL be held stable in DONE until out_ready=1 at an edge, which SHALL return the FSM to IDLE.
REQ-022 A new operand SHALL NOT be accepted on the same edge as a DONE handshake; in_ready rises the cycle after.
REQ-023 Magnitude 2^(WIDTH-1) (the abs of the most negative input) SHALL be treated as unsigned.
REQ-024 The maximum magnitude product 2^(2*WIDTH-2) SHALL fit without overflow.
REQ-025 in_valid, mag_*, and sign_* SHALL be ignored outside IDLE; input changes during BUSY SHALL NOT affect the result.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 No early termination: latency SHALL be WIDTH edges even for zero operands.

Reset
REQ-028 rst_n=0 SHALL asynchronously force the following:
  - state=IDLE, in_ready=1, out_valid=0, busy=0;
  - product=0, accumulator=0, counter=0.
REQ-029 Reset asserted mid-BUSY or mid-DONE SHALL discard the in-flight operation; no out_valid pulse follows deassertion.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package mult_pkg SHALL hold:
  - the state enum (IDLE, BUSY, DONE);
  - the default WIDTH constant;
  - the counter width constant, $clog2(WIDTH)+1.
REQ-032 The output sign application SHALL be one sub-module, product_negate, 2*WIDTH wide, computing ~x+1, instantiated once.
REQ-033 All state SHALL be in a single clocked process with async active-low reset; next-state logic SHALL be separate and combinational.

Verification
REQ-034 Scenario: mag_a=3, sign_a=0, mag_b=5, sign_b=1, accept at edge 0 -> out_valid=1 after edge 16, product=32'hFFFFFFF1 (-15).
REQ-035 Scenario: mag_a=0, sign_a=1, mag_b=7, sign_b=0 -> product=0 (not -0), latency 16.
REQ-036 Scenario: mag_a=16'h8000, sign_a=1, mag_b=16'h8000, sign_b=1 -> product=32'h40000000.
REQ-037 Scenario: out_ready held 0 for 5 cycles in DONE -> product stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1 the following cycle.
REQ-038 Scenario: toggle mag_a/mag_b every cycle during BUSY with operands 100 and -200 (mag 200, sign 1) -> product=-20000 (32'hFFFFB1E0).
REQ-039 Scenario: rst_n pulsed low at BUSY edge 8 -> outputs reset immediately; no out_valid after release; next accept of 2x2 yields 4 at latency 16.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the sign-magnitude multiplier
package mult_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Counter must be able to hold the value WIDTH itself, hence the extra bit
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/product_negate.sv
// rtl/product_negate.sv - two's-complement negation used to apply the result sign
module product_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    assign y = ~x + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/sign_mag_mult16.sv
// rtl/sign_mag_mult16.sv - iterative shift-add multiplier on sign-magnitude operands
module sign_mag_mult16
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   mag_a,
    input  logic [WIDTH-1:0]   mag_b,
    input  logic               sign_a,
    input  logic               sign_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);

    state_t          state, state_n;
    logic [PW-1:0]   mcand, mcand_n;
    logic [WIDTH-1:0] mplier, mplier_n;
    logic [PW-1:0]   acc, acc_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            rsign, rsign_n;
    logic [PW-1:0]   product_n;
    logic            in_ready_n, out_valid_n, busy_n;

    logic [PW-1:0]   acc_step;
    logic [PW-1:0]   acc_step_neg;
    logic [CW-1:0]   cnt_inc;

    // One iteration of the shift-add datapath, kept outside the FSM block so the
    // negator can feed back into it without a combinational loop
    always_comb begin
        acc_step = mplier[0] ? (acc + mcand) : acc;
        cnt_inc  = cnt + {{(CW-1){1'b0}}, 1'b1};
    end

    product_negate #(.W(PW)) u_negate (
        .x (acc_step),
        .y (acc_step_neg)
    );

    // Next-state and next-datapath decode
    always_comb begin
        state_n   = state;
        mcand_n   = mcand;
        mplier_n  = mplier;
        acc_n     = acc;
        cnt_n     = cnt;
        rsign_n   = rsign;
        product_n = product;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    mcand_n  = {{WIDTH{1'b0}}, mag_a};
                    mplier_n = mag_b;
                    rsign_n  = sign_a ^ sign_b;
                    acc_n    = '0;
                    cnt_n    = '0;
                    state_n  = BUSY;
                end
            end
            BUSY: begin
                acc_n    = acc_step;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt_inc;
                if (cnt_inc == CW'(WIDTH)) begin
                    state_n = DONE;
                    // A zero magnitude stays positive regardless of the sign bit
                    product_n = (rsign && (acc_step != '0)) ? acc_step_neg : acc_step;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        in_ready_n  = (state_n == IDLE);
        out_valid_n = (state_n == DONE);
        busy_n      = (state_n == BUSY);
    end

    // All state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            rsign     <= 1'b0;
            product   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            mcand     <= mcand_n;
            mplier    <= mplier_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            rsign     <= rsign_n;
            product   <= product_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_sign_mag_mult16.sv
// tb/tb_sign_mag_mult16.sv - directed vector bench for sign_mag_mult16
module tb_sign_mag_mult16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mag_a;
    logic [15:0] mag_b;
    logic        sign_a;
    logic        sign_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int total;
    int bad;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sa;
        logic        sb;
        bit          tog;
        int          hold;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    sign_mag_mult16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({nm, " in_ready_before"}, {31'd0, in_ready}, 32'd1);
        mag_a    = v.a;
        mag_b    = v.b;
        sign_a   = v.sa;
        sign_b   = v.sb;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({nm, " busy_after_accept"}, {30'd0, busy, in_ready}, 32'd2);
        if (!v.tog) in_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            if (v.tog) begin
                mag_a    = 16'($urandom);
                mag_b    = 16'($urandom);
                sign_a   = 1'($urandom);
                sign_b   = 1'($urandom);
                in_valid = 1'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        in_valid = 1'b0;
        check({nm, " latency"}, 32'(lat), 32'd16);
        check({nm, " product"}, product, v.exp);
        check({nm, " flags_in_done"}, {29'd0, busy, in_ready, out_valid}, 32'd1);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check({nm, " hold_product"}, product, v.exp);
            check({nm, " hold_flags"}, {30'd0, in_ready, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({nm, " after_handshake"}, {30'd0, out_valid, in_ready}, 32'd1);
        check({nm, " product_kept"}, product, v.exp);
    endtask

    initial begin
        int seen;
        vec_t v;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mag_a     = '0;
        mag_b     = '0;
        sign_a    = 1'b0;
        sign_b    = 1'b0;

        //            a        b        sa    sb    tog hold exp
        vecs[0] = '{16'd3,    16'd5,    1'b0, 1'b1, 0,  5,  32'hFFFFFFF1};
        vecs[1] = '{16'd0,    16'd7,    1'b1, 1'b0, 0,  0,  32'h00000000};
        vecs[2] = '{16'h8000, 16'h8000, 1'b1, 1'b1, 0,  1,  32'h40000000};
        vecs[3] = '{16'd100,  16'd200,  1'b0, 1'b1, 1,  0,  32'hFFFFB1E0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 0,    0,  0,  32'hFFFE0001};
        vecs[5] = '{16'hFFFF, 16'd1,    1'b1, 1'b0, 0,  2,  32'hFFFF0001};
        vecs[6] = '{16'd7,    16'd0,    1'b0, 1'b1, 0,  0,  32'h00000000};
        vecs[7] = '{16'h1234, 16'd1,    1'b1, 1'b0, 0,  0,  32'hFFFFEDCC};
        vecs[8] = '{16'd1,    16'd1,    1'b1, 1'b1, 0,  0,  32'h00000001};

        #12;
        check("reset_flags", {29'd0, busy, in_ready, out_valid}, 32'd2);
        check("reset_product", product, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Prior product (1) is nonzero so the async clear is observable
        v = '{16'd5, 16'd5, 1'b0, 1'b0, 0, 0, 32'd25};
        mag_a    = v.a;
        mag_b    = v.b;
        sign_a   = 1'b0;
        sign_b   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midbusy_reset_flags", {29'd0, busy, in_ready, out_valid}, 32'd2);
        check("midbusy_reset_product", product, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        check("no_valid_after_reset", 32'(seen), 32'd0);

        v = '{16'd2, 16'd2, 1'b0, 1'b0, 0, 0, 32'd4};
        run_op(v, "post_reset_2x2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
